// File: rtl/cbs1_fmap_writer.sv
// -----------------------------------------------------------------------------
// cbs1_fmap_writer
//
// Collects the three per-channel 160-bit CBS result words from the first CBS
// stage and writes them to the stage-2 feature-map memory in raster order.
// The words pass through a small first-word-fall-through FIFO so the memory
// can apply backpressure. `start` arms a frame of ROWS*COLS words, and
// `frame_done` pulses once the final word has been written.
//
// Ports
//   clk                      single clock, rising edge
//   reset                    asynchronous, active-low; clears all state
//   start                    one-cycle pulse, arms a frame when idle
//   in_valid / in_ready      input handshake for data_in1..3
//   data_in1..3              channel 1/2/3 CBS words (160 bits each)
//   wr_en / wr_ready         write handshake towards the feature memory
//   wr_addr                  word address, row*COLS + col
//   wr_data1..3              head FIFO entry, zero while the FIFO is empty
//   busy                     high while a frame is running
//   frame_done               one-cycle pulse after the last write
// -----------------------------------------------------------------------------
module cbs1_fmap_writer #(
    parameter int ROWS   = 40,
    parameter int COLS   = 128,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [159:0]      data_in1,
    input  logic [159:0]      data_in2,
    input  logic [159:0]      data_in3,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [159:0]      wr_data1,
    output logic [159:0]      wr_data2,
    output logic [159:0]      wr_data3,
    output logic              busy,
    output logic              frame_done
);

    localparam int TOTAL = ROWS * COLS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   TOTAL_W   = (ADDR_W + 1)'(TOTAL);
    localparam logic [CNT_W-1:0]  DEPTH_W   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO storage: one entry holds all three channel words {ch3, ch2, ch1}.
    logic [479:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [479:0]      head;

    logic [ADDR_W:0]   accepted_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;

    logic run;
    logic fifo_empty;
    logic push;
    logic pop;
    logic last_word;
    logic arm;

    // -------------------------------------------------------------------------
    // Handshake decode. Everything here depends on registered state and the
    // two handshake inputs only; in_ready and wr_en never look at in_valid.
    // -------------------------------------------------------------------------
    assign run        = (state_q == RUN);
    assign fifo_empty = (count_q == '0);
    // A full FIFO refuses input even if a pop happens in the same cycle.
    assign in_ready   = run && (count_q < DEPTH_W) && (accepted_q < TOTAL_W);
    assign wr_en      = run && !fifo_empty;
    assign push       = in_valid && in_ready;
    assign pop        = wr_en && wr_ready;
    assign last_word  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign arm        = (state_q == IDLE) && start;

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pop && last_word) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an empty FIFO is defined purely by
    // count_q, and the read mux forces zero then, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {data_in3, data_in2, data_in1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;  // idle, or push and pop together
            endcase
        end
    end

    // First-word-fall-through: the head entry is presented directly.
    assign head     = fifo_mem[rd_ptr_q];
    assign wr_data1 = fifo_empty ? '0 : head[159:0];
    assign wr_data2 = fifo_empty ? '0 : head[319:160];
    assign wr_data3 = fifo_empty ? '0 : head[479:320];

    // -------------------------------------------------------------------------
    // Frame length and raster address counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accepted_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else if (arm) begin
            accepted_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            if (push) accepted_q <= accepted_q + 1'b1;
            if (pop) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    // The final word wraps the row back to 0 as well.
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign wr_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);

endmodule

// File: tb/tb_cbs1_fmap_writer.sv
// -----------------------------------------------------------------------------
// tb_cbs1_fmap_writer
//
// Bench for cbs1_fmap_writer with a 4x3 frame and a 4-entry FIFO. A driver
// applies randomised traffic; a reference model predicts frame state, input
// acceptance and queues the expected writes (address = word index in the
// frame); a separate monitor compares every offered write against the head of
// that queue.
//
// Cycle phases (period 20): inputs change at negedge, monitor samples at
// negedge+2, model samples at negedge+3, async reset events at negedge+5.
// -----------------------------------------------------------------------------
module tb_cbs1_fmap_writer;

    localparam int ROWS   = 4;
    localparam int COLS   = 3;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int TOTAL  = ROWS * COLS;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [159:0]      data_in1, data_in2, data_in3;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [159:0]      wr_data1, wr_data2, wr_data3;
    logic              busy;
    logic              frame_done;

    cbs1_fmap_writer #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data1   (wr_data1),
        .wr_data2   (wr_data2),
        .wr_data3   (wr_data3),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [159:0]      d1;
        logic [159:0]      d2;
        logic [159:0]      d3;
    } exp_t;

    exp_t exp_q[$];

    int n_checks   = 0;
    int n_fail     = 0;

    // Reference model state
    bit m_run      = 0;
    bit m_done     = 0;
    int pushed     = 0;   // words accepted in the current frame
    int wr_cnt     = 0;   // writes completed in the current frame
    int done_seen  = 0;   // frame_done pulses observed
    int acc_seen   = 0;   // DUT-reported accepts, all time
    bit last_pop   = 0;
    bit popped     = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    function automatic logic [159:0] rnd160();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            last_pop = 0;
            popped   = 0;
            if (!reset) continue;
            check("wr_en", wr_en, (m_run && exp_q.size() > 0));
            if (wr_en && exp_q.size() > 0) begin
                check("wr_addr",  wr_addr,  exp_q[0].addr);
                check("wr_data1", wr_data1, exp_q[0].d1);
                check("wr_data2", wr_data2, exp_q[0].d2);
                check("wr_data3", wr_data3, exp_q[0].d3);
                if (wr_ready) begin
                    if (exp_q[0].addr == ADDR_W'(TOTAL - 1)) last_pop = 1;
                    void'(exp_q.pop_front());
                    popped = 1;
                    wr_cnt++;
                end
            end else if (exp_q.size() == 0) begin
                check("wr_data1 empty", wr_data1, '0);
            end
        end
    end

    // ---------------------------------------------------------------- model
    initial begin
        int  occ;
        bit  want_rdy;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                exp_q.delete();
                m_run  = 0;
                m_done = 0;
                pushed = 0;
                wr_cnt = 0;
                continue;
            end
            occ      = exp_q.size() + (popped ? 1 : 0);
            want_rdy = m_run && (occ < DEPTH) && (pushed < TOTAL);
            check("busy",       busy,       m_run);
            check("frame_done", frame_done, m_done);
            check("in_ready",   in_ready,   want_rdy);
            if (frame_done) done_seen++;
            if (in_valid && in_ready) acc_seen++;
            if (in_valid && want_rdy) begin
                e.addr = ADDR_W'(pushed);
                e.d1   = data_in1;
                e.d2   = data_in2;
                e.d3   = data_in3;
                exp_q.push_back(e);
                pushed++;
            end
            if (m_done) begin
                m_done = 0;
            end else if (m_run) begin
                if (last_pop) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end else if (start) begin
                m_run  = 1;
                pushed = 0;
                wr_cnt = 0;
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic cyc(input bit v, input bit r, input bit s);
        @(negedge clk);
        in_valid = v;
        wr_ready = r;
        start    = s;
        data_in1 = 160'(pushed);
        data_in2 = rnd160();
        data_in3 = rnd160();
    endtask

    task automatic run_until(input int target, input int pv, input int pr, input int mid_start);
        for (int c = 0; c < 400; c++) begin
            if (done_seen >= target) return;
            cyc($urandom_range(99) < pv, $urandom_range(99) < pr, c == mid_start);
        end
        timeout("frame completion");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " in_ready"},   in_ready,   '0);
        check({tag, " wr_en"},      wr_en,      '0);
        check({tag, " busy"},       busy,       '0);
        check({tag, " frame_done"}, frame_done, '0);
        check({tag, " wr_addr"},    wr_addr,    '0);
        check({tag, " wr_data1"},   wr_data1,   '0);
        check({tag, " wr_data2"},   wr_data2,   '0);
        check({tag, " wr_data3"},   wr_data3,   '0);
    endtask

    // Asynchronous reset applied mid-cycle, away from any clock edge.
    task automatic async_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        #5 reset = 1'b0;
        #1 check_outputs_zero("async reset");
        repeat (2) @(negedge clk);
        #5 reset = 1'b1;
    endtask

    initial begin
        int a0;
        bit hit;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        wr_ready = 1'b0;
        data_in1 = '0;
        data_in2 = '0;
        data_in3 = '0;
        #1 reset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        #5 reset = 1'b1;

        // Frame 1: random valid / ready traffic.
        cyc(0, 1, 1);
        run_until(1, 70, 70, -1);

        // Frame 2: memory stalled for 10 cycles while words are offered,
        // then released with in_valid held high past the frame end.
        cyc(0, 0, 1);
        a0 = acc_seen;
        repeat (10) cyc(1, 0, 0);
        #4 check("accepted while stalled", 160'(acc_seen - a0), 160'(DEPTH));
        run_until(2, 100, 100, -1);
        repeat (4) cyc(1, 1, 0);

        // Frame 3: a start pulse mid-frame must be ignored.
        cyc(0, 1, 1);
        run_until(3, 60, 80, 5);

        // Frame 4: armed with no input offered, then reset after 3 writes.
        cyc(0, 1, 1);
        repeat (3) cyc(0, 1, 0);
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            cyc($urandom_range(99) < 80, 1, 0);
            if (wr_cnt >= 3) begin
                hit = 1;
                break;
            end
        end
        if (!hit) timeout("three writes before reset");
        async_reset();

        // Frame 5: restarts from address 0.
        cyc(0, 1, 1);
        run_until(4, 70, 70, -1);
        repeat (3) cyc(1, 1, 0);

        @(negedge clk);
        #4;
        check("frame_done pulses", 160'(done_seen), 160'(4));
        check("scoreboard drained", 160'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cbs1_fmap_writer.md
# cbs1_fmap_writer

Downstream neighbour of the first CBS stage. Accepts the three 160-bit per-channel CBS result words that stage produces, buffers them in a small FIFO and writes them to the stage-2 feature-map memory in raster order under memory backpressure. A frame is armed by `start`, and completion is flagged once `ROWS*COLS` words have been written.

## Interface
- `ROWS`, 40, feature-map rows per frame.
- `COLS`, 128, 160-bit words per row.
- `ADDR_W`, 13, write address width (`ROWS*COLS` ≤ 2^ADDR_W).
- `DEPTH`, 4, FIFO entries (power of 2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  one-cycle pulse; arms a frame when in IDLE.
- `in_valid`  in  1  CBS words on `data_in1..3` are valid.
- `in_ready`  out  1  writer can accept this cycle.
- `data_in1`, `data_in2`, `data_in3`  in  160 each  channel 1/2/3 CBS words.
- `wr_en`  out  1  write request to feature memory.
- `wr_ready`  in  1  memory accepts the write this cycle.
- `wr_addr`  out  ADDR_W  word address.
- `wr_data1`, `wr_data2`, `wr_data3`  out  160 each  channel words.
- `busy`  out  1  high in RUN.
- `frame_done`  out  1  one-cycle pulse after the last write.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DONE when the write handshake of word index `ROWS*COLS-1` completes.
  - DONE → IDLE unconditionally after 1 cycle.
  - `start` is ignored outside IDLE.
- Input push: a push occurs when `in_valid && in_ready`. All three channel words form one 480-bit FIFO entry.
- `in_ready` = RUN && `fifo_count < DEPTH` && `accepted < ROWS*COLS`.
  - Words offered beyond the frame length are not accepted.
  - A full FIFO deasserts `in_ready` even in a cycle when a pop occurs. No same-cycle push-when-full.
- FIFO is first-word-fall-through. `wr_data1..3` always show the head entry and are 0 when the FIFO is empty.
- `wr_en` = RUN && FIFO non-empty. A pop and an address advance happen only on `wr_en && wr_ready`.
- While `wr_ready` is low, `wr_en`, `wr_addr` and `wr_data*` hold stable.
- Address generation uses column counter `col` (0..COLS-1) and row counter `row` (0..ROWS-1).
  - `wr_addr` = `row*COLS + col`, computed in ADDR_W bits with no truncation.
  - On each write handshake `col` increments. At `COLS-1` it wraps to 0 and `row` increments.
  - After the final word both counters return to 0.
- `accepted` counter: counts pushes, clears on entry to RUN. Width is `ADDR_W+1`.
- Simultaneous push and pop in one cycle: `fifo_count` is unchanged and both pointers advance.
- `frame_done` is asserted in the DONE cycle only.
- Reset asserted mid-frame: FSM goes to IDLE, FIFO is flushed, and all counters and outputs clear immediately. No partial-frame completion is reported.

## Timing
- Reset values:
  - `in_ready`, `wr_en`, `busy`, `frame_done` = 0.
  - `wr_addr` = 0, `wr_data1..3` = 0.
  - FSM = IDLE.
- `start` sampled at edge N: `busy` and `in_ready` are high from N+1.
- Latency: a word pushed at edge N is on `wr_data*` with `wr_en` = 1 from N+1 (FIFO was empty).
- Throughput: 1 word/cycle sustained when `in_valid` and `wr_ready` are both held high.
- Last write handshake at edge M: `frame_done` = 1 and `busy` = 0 during M+1. IDLE is entered at M+2.
- All outputs are registered or derived from registered state only. There is no combinational path from `in_valid` to `wr_en`.

## Test plan
- Basic frame (`ROWS`=2, `COLS`=3), `start`, then 6 words with `wr_ready` = 1 and channel-1 data = index:
  - `wr_addr` sequence is 0,1,2,3,4,5, each with matching data.
  - `frame_done` pulses once, 1 cycle after addr 5.
  - `busy` falls with `frame_done`.
- Backpressure: `wr_ready` = 0 for 10 cycles while words are offered:
  - Exactly 4 words are accepted, then `in_ready` = 0.
  - `wr_addr`/`wr_data` are stable throughout.
  - After release, words drain in order with no loss or duplication.
- Row wrap (`COLS`=3, `ROWS`=4): the 4th write goes to addr 3 (row=1, col=0), and the final write goes to addr 11.
- Over-offer: `in_valid` is held high after the 6th word of a 2×3 frame. `in_ready` stays 0 and no 7th write occurs.
- `start` during RUN is ignored (address sequence uninterrupted). `start` in IDLE without `in_valid` gives `busy` = 1, `wr_en` = 0.
- `reset` low mid-frame after 3 writes: all outputs go to 0 asynchronously and `frame_done` never pulses. A new `start` then writes again from addr 0.
